// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int INST_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: imem request/response, redirect, and decode handoff.
interface fetch_if import fetch_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; storage is left unreset, only pointers and count are reset.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, prefetch buffer, redirect flush.
// Optional FETCH_PERF_CNT_EN adds delivered/redirect counters (perf_fetched, perf_flushes).
module fetch_unit import fetch_pkg::*; #(
  parameter int              ADDR_W     = ADDR_W_DEF,
  parameter int              INST_W     = INST_W_DEF,
  parameter int              FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_if.master     bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushes
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + INST_W;

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  inflight_nxt;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ENT_W-1:0]  head;
  logic              fifo_empty;
  logic              credit;
  logic              req_hs;
  logic              deliver;
  logic              rsp_keep;
  logic              unused_flags;

  // Buffered words plus outstanding requests may never exceed the buffer depth.
  assign credit       = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (CNT_W+1)'(FIFO_DEPTH);
  assign bus.imem_req_valid = (state == RUN) && credit;
  assign bus.imem_req_addr  = pc;
  assign req_hs       = bus.imem_req_valid && bus.imem_req_ready;
  assign deliver      = bus.inst_valid && bus.inst_ready;
  assign rsp_keep     = bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect_valid;
  assign inflight_nxt = inflight + CNT_W'(req_hs) - CNT_W'(bus.imem_rsp_valid);

  logic pcq_full, pcq_empty, pf_full;
  assign unused_flags = &{1'b0, pcq_full, pcq_empty, pf_full};

  // PCs of outstanding requests; its occupancy is the in-flight count.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_W)) u_pcq (
    .clk(clk), .rst_n(rst_n),
    .push(req_hs), .push_data(pc),
    .pop(bus.imem_rsp_valid), .flush(1'b0),
    .head(rsp_pc), .full(pcq_full), .empty(pcq_empty), .count(inflight)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_W)) u_prefetch (
    .clk(clk), .rst_n(rst_n),
    .push(rsp_keep), .push_data({rsp_pc, bus.imem_rsp_data}),
    .pop(deliver), .flush(bus.redirect_valid),
    .head(head), .full(pf_full), .empty(fifo_empty), .count(fifo_cnt)
  );

  assign bus.inst_valid = !fifo_empty;
  assign bus.inst_data  = fifo_empty ? '0 : head[INST_W-1:0];
  assign bus.inst_pc    = fifo_empty ? '0 : head[ENT_W-1:INST_W];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = RUN;
      RUN:   if (bus.redirect_valid && (inflight_nxt != '0)) state_nxt = FLUSH;
      FLUSH: begin
        if (bus.redirect_valid)
          state_nxt = (inflight_nxt != '0) ? FLUSH : RUN;
        else if ((drop_cnt == '0) || ((drop_cnt == CNT_W'(1)) && bus.imem_rsp_valid))
          state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (bus.redirect_valid)  pc <= bus.redirect_pc;
      else if (req_hs)         pc <= pc + ADDR_W'(PC_STEP);
      // Everything still outstanding after a redirect belongs to the old path.
      if (bus.redirect_valid)
        drop_cnt <= inflight_nxt;
      else if (bus.imem_rsp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (deliver)            perf_fetched <= perf_fetched + 32'd1;
      if (bus.redirect_valid) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: epoch-tagged imem/decode model plus directed scenarios.
// Covers FETCH_PERF_CNT_EN counters when that macro is defined.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  fetch_unit #(.ADDR_W(32), .INST_W(32), .FIFO_DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } acc_t;

  acc_t        accq[$];
  int          cyc = 0;
  int          lat = 1;
  int          epoch, live, avail, up, ndel, nred, rr_idx;
  int          total = 0;
  int          bad = 0;
  logic [31:0] req_exp, del_exp, fa_pc, fa_data;
  logic [31:0] rr [2];
  bit          fa_flag;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // imem: in-order responses exactly lat cycles after acceptance
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rst_n && accq.size() > 0 && accq[0].due == cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(accq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  end

  always @(negedge clk) begin
    int stale, occ;
    if (!rst_n) begin
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_req_addr", bus.imem_req_addr, 32'h0);
      chk("rst_inst_data", bus.inst_data, 32'h0);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_perf_fetched", perf_fetched, 32'd0);
      chk("rst_perf_flushes", perf_flushes, 32'd0);
`endif
      accq.delete();
      epoch = 0; live = 0; avail = 0; up = 0; ndel = 0; nred = 0; rr_idx = 0;
      req_exp = 32'h0; del_exp = 32'h0; fa_flag = 1'b1;
    end else begin
      stale = 0;
      foreach (accq[i]) if (accq[i].epoch != epoch) stale++;
      occ = live + stale;
      chk("req_valid", 32'(bus.imem_req_valid), 32'(up >= 1 && stale == 0 && occ < 4));
      chk("inst_valid", 32'(bus.inst_valid), 32'(avail > 0));
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, 32'(ndel));
      chk("perf_flushes", perf_flushes, 32'(nred));
`endif
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("req_addr", bus.imem_req_addr, req_exp);
        accq.push_back(acc_t'{bus.imem_req_addr, epoch, cyc + lat});
        req_exp = req_exp + 32'd4;
        live++;
        if (rr_idx < 2) rr[rr_idx] = bus.imem_req_addr;
        rr_idx++;
      end
      if (bus.inst_valid && bus.inst_ready) begin
        chk("inst_pc", bus.inst_pc, del_exp);
        chk("inst_data", bus.inst_data, mem_word(del_exp));
        if (fa_flag) begin
          fa_pc = bus.inst_pc; fa_data = bus.inst_data; fa_flag = 1'b0;
        end
        del_exp = del_exp + 32'd4;
        live--; avail--; ndel++;
      end
      if (bus.imem_rsp_valid && accq.size() > 0) begin
        if (accq[0].epoch == epoch) avail++;
        void'(accq.pop_front());
      end
      if (bus.redirect_valid) begin
        epoch++; live = 0; avail = 0; nred++; rr_idx = 0; fa_flag = 1'b1;
        req_exp = bus.redirect_pc; del_exp = bus.redirect_pc;
      end
      up++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = t;
    tick(1);
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick(3);
    rst_n = 1'b1;

    tick(20);
    chk("first_pc", fa_pc, 32'h0);
    chk("first_data", fa_data, 32'hDEAD_BEEF);

    bus.inst_ready = 1'b0;
    tick(10);
    chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("stall_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("stall_buffered", 32'(avail), 32'd4);
    bus.inst_ready = 1'b1;
    tick(20);

    bus.imem_req_ready = 1'b0;
    tick(4);
    lat = 2;
    bus.imem_req_ready = 1'b1;
    tick(10);
    chk("two_in_flight", 32'(accq.size()), 32'd2);
    redirect_to(32'h100);
    chk("flush_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("flush_inst_valid", 32'(bus.inst_valid), 32'd0);
    tick(20);
    chk("redir_first_pc", fa_pc, 32'h100);
    chk("redir_first_data", fa_data, 32'h100 ^ 32'hDEAD_BEEF);

    redirect_to(32'h20);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (bus.imem_req_valid && bus.imem_req_addr == 32'h20) found = 1'b1;
      else tick(1);
    end
    chk("reach_pc20", 32'(found), 32'd1);
    if (found) redirect_to(32'h200);
    tick(20);
    chk("same_cycle_first_pc", fa_pc, 32'h200);

    redirect_to(32'hFFFF_FFFC);
    tick(20);
    chk("wrap_req0", rr[0], 32'hFFFF_FFFC);
    chk("wrap_req1", rr[1], 32'h0000_0000);

    tick(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_addr", bus.imem_req_addr, 32'h0);
    chk("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
    tick(2);
    rst_n = 1'b1;

`ifdef FETCH_PERF_CNT_EN
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      bus.inst_ready = (ndel < 6);
      if (ndel >= 6) found = 1'b1;
      else tick(1);
    end
    bus.inst_ready = 1'b0;
    chk("perf_reach6", 32'(found), 32'd1);
    redirect_to(32'h40);
    tick(3);
    redirect_to(32'h80);
    tick(3);
    chk("perf_fetched_6", perf_fetched, 32'd6);
    chk("perf_flushes_2", perf_flushes, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("perf_rst_fetched", perf_fetched, 32'd0);
    chk("perf_rst_flushes", perf_flushes, 32'd0);
    tick(1);
    rst_n = 1'b1;
    bus.inst_ready = 1'b1;
`endif
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
